// File: rtl/scmi_mbox_pkg.sv
// scmi_mbox_pkg: FSM states, mailbox register offsets and default AXI-lite channel structs
package scmi_mbox_pkg;
  typedef enum logic [3:0] {
    IDLE, WR_LEN, WR_HDR, WR_PLD, WR_DB, WAIT_IRQ, RD_HDR, RD_PLD, CLR_CMP, RESP
  } scmi_state_e;
  localparam logic [7:0] SCMI_OFS_LENGTH     = 8'h14;
  localparam logic [7:0] SCMI_OFS_HDR        = 8'h18;
  localparam logic [7:0] SCMI_OFS_PAYLOAD    = 8'h1C;
  localparam logic [7:0] SCMI_OFS_DOORBELL   = 8'h20;
  localparam logic [7:0] SCMI_OFS_COMPLETION = 8'h24;
  localparam logic [1:0] AXI_RESP_OKAY       = 2'b00;
  // Address fields are carried at the widest supported width; unused upper bits stay zero
  typedef struct packed {
    logic [63:0] aw_addr;
    logic [2:0]  aw_prot;
    logic        aw_valid;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid;
    logic        b_ready;
    logic [63:0] ar_addr;
    logic [2:0]  ar_prot;
    logic        ar_valid;
    logic        r_ready;
  } mbox_axi_req_t;
  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
  } mbox_axi_rsp_t;
  function automatic logic [63:0] mbox_addr(logic [63:0] base, logic [7:0] ofs, int unsigned aw);
    logic [63:0] mask;
    mask = (aw >= 64) ? '1 : ((64'd1 << aw) - 64'd1);
    return (base + 64'(ofs)) & mask;
  endfunction
endpackage

// File: rtl/axi_lite_single_mgr.sv
// axi_lite_single_mgr: one AXI-lite beat while start is held; done marks the B/R handshake cycle
module axi_lite_single_mgr
  import scmi_mbox_pkg::*;
#(
  parameter type axi_lite_req_t  = mbox_axi_req_t,
  parameter type axi_lite_resp_t = mbox_axi_rsp_t
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start,
  input  logic           write,
  input  logic [63:0]    addr,
  input  logic [31:0]    wdata,
  output logic           done,
  output logic [31:0]    rdata,
  output logic           err,
  output axi_lite_req_t  axi_req_o,
  input  axi_lite_resp_t axi_rsp_i
);
  logic aw_done, w_done, ar_done;
  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw_addr  = addr;
    axi_req_o.aw_valid = start && write && !aw_done;
    axi_req_o.w_data   = wdata;
    axi_req_o.w_strb   = 4'hF;
    axi_req_o.w_valid  = start && write && !w_done;
    axi_req_o.b_ready  = start && write;
    axi_req_o.ar_addr  = addr;
    axi_req_o.ar_valid = start && !write && !ar_done;
    axi_req_o.r_ready  = start && !write && ar_done;
  end
  assign done  = (axi_req_o.b_ready && axi_rsp_i.b_valid) || (axi_req_o.r_ready && axi_rsp_i.r_valid);
  assign rdata = axi_rsp_i.r_data;
  assign err   = done && ((write ? axi_rsp_i.b_resp : axi_rsp_i.r_resp) != AXI_RESP_OKAY);
  // Per-channel accept flags let AW and W retire independently; cleared when the beat completes
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      ar_done <= 1'b0;
    end else if (done) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      ar_done <= 1'b0;
    end else begin
      aw_done <= aw_done || (axi_req_o.aw_valid && axi_rsp_i.aw_ready);
      w_done  <= w_done || (axi_req_o.w_valid && axi_rsp_i.w_ready);
      ar_done <= ar_done || (axi_req_o.ar_valid && axi_rsp_i.ar_ready);
    end
endmodule

// File: rtl/scmi_mbox_initiator.sv
// scmi_mbox_initiator: sends one SCMI message through a mailbox window and returns the reply
module scmi_mbox_initiator
  import scmi_mbox_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter logic [63:0] MBOX_BASE      = '0,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter type         axi_lite_req_t  = mbox_axi_req_t,
  parameter type         axi_lite_resp_t = mbox_axi_rsp_t
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic [31:0]    req_hdr_i,
  input  logic [31:0]    req_payload_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [31:0]    rsp_hdr_o,
  output logic [31:0]    rsp_payload_o,
  output logic           rsp_err_o,
  output logic           rsp_timeout_o,
  input  logic           irq_completion_i,
  output axi_lite_req_t  axi_req_o,
  input  axi_lite_resp_t axi_rsp_i,
  output logic           busy_o
);
  localparam int unsigned CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  scmi_state_e   state, state_n;
  logic [31:0]   hdr_q, pld_q, rsp_hdr_q, rsp_pld_q;
  logic          err_q, to_q;
  logic [CW-1:0] cnt;
  logic [7:0]    ofs;
  logic [31:0]   wdata, rdata;
  logic          start, write, done, err, expire;
  always_comb begin
    ofs   = SCMI_OFS_LENGTH;
    wdata = 32'd8;
    case (state)
      WR_HDR:  begin ofs = SCMI_OFS_HDR;        wdata = hdr_q; end
      WR_PLD:  begin ofs = SCMI_OFS_PAYLOAD;    wdata = pld_q; end
      WR_DB:   begin ofs = SCMI_OFS_DOORBELL;   wdata = 32'd1; end
      RD_HDR:  begin ofs = SCMI_OFS_HDR;        wdata = '0;    end
      RD_PLD:  begin ofs = SCMI_OFS_PAYLOAD;    wdata = '0;    end
      CLR_CMP: begin ofs = SCMI_OFS_COMPLETION; wdata = '0;    end
      default: ;
    endcase
  end
  assign start  = !(state inside {IDLE, WAIT_IRQ, RESP});
  assign write  = !(state inside {RD_HDR, RD_PLD});
  assign expire = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
  axi_lite_single_mgr #(
    .axi_lite_req_t (axi_lite_req_t),
    .axi_lite_resp_t(axi_lite_resp_t)
  ) u_mgr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start    (start),
    .write    (write),
    .addr     (mbox_addr(MBOX_BASE, ofs, AXI_ADDR_WIDTH)),
    .wdata    (wdata),
    .done     (done),
    .rdata    (rdata),
    .err      (err),
    .axi_req_o(axi_req_o),
    .axi_rsp_i(axi_rsp_i)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = req_valid_i ? WR_LEN : IDLE;
      WR_LEN:   state_n = done ? WR_HDR : WR_LEN;
      WR_HDR:   state_n = done ? WR_PLD : WR_HDR;
      WR_PLD:   state_n = done ? WR_DB : WR_PLD;
      WR_DB:    state_n = done ? WAIT_IRQ : WR_DB;
      WAIT_IRQ: state_n = irq_completion_i ? RD_HDR : expire ? CLR_CMP : WAIT_IRQ;
      RD_HDR:   state_n = done ? RD_PLD : RD_HDR;
      RD_PLD:   state_n = done ? CLR_CMP : RD_PLD;
      CLR_CMP:  state_n = done ? RESP : CLR_CMP;
      RESP:     state_n = rsp_ready_i ? IDLE : RESP;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state     <= IDLE;
      hdr_q     <= '0;
      pld_q     <= '0;
      rsp_hdr_q <= '0;
      rsp_pld_q <= '0;
      err_q     <= 1'b0;
      to_q      <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state == WAIT_IRQ) ? cnt + 1'b1 : '0;
      if (state == IDLE && req_valid_i) begin
        hdr_q     <= req_hdr_i;
        pld_q     <= req_payload_i;
        rsp_hdr_q <= '0;
        rsp_pld_q <= '0;
        err_q     <= 1'b0;
        to_q      <= 1'b0;
      end
      if (err) err_q <= 1'b1;
      if (done && state == RD_HDR) rsp_hdr_q <= rdata;
      if (done && state == RD_PLD) rsp_pld_q <= rdata;
      // A completion irq arriving on the expiry cycle wins over the timeout
      if (state == WAIT_IRQ && !irq_completion_i && expire) to_q <= 1'b1;
    end
  assign req_ready_o   = (state == IDLE) && !rst_i;
  assign busy_o        = state != IDLE;
  assign rsp_valid_o   = state == RESP;
  assign rsp_hdr_o     = rsp_hdr_q;
  assign rsp_payload_o = rsp_pld_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = to_q;
endmodule

// File: tb/tb_scmi_mbox_initiator.sv
// tb_scmi_mbox_initiator: mailbox subordinate model, per-cycle checker and directed scenarios
module tb_scmi_mbox_initiator;
  import scmi_mbox_pkg::*;
  localparam logic [63:0] BASE = 64'hF_4000_0000;
  localparam int TO = 16;
  localparam logic [7:0] O_LEN = 8'h14, O_HDR = 8'h18, O_PLD = 8'h1C, O_DB = 8'h20, O_CMP = 8'h24;
  typedef struct {logic wr; logic [63:0] addr; logic [31:0] data;} ent_t;
  logic clk = 0, rst = 1, req_valid = 0, rsp_ready = 1, irq = 0;
  logic [31:0] req_hdr = 0, req_payload = 0;
  logic req_ready, rsp_valid, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_hdr, rsp_payload;
  mbox_axi_req_t axi_req;
  mbox_axi_rsp_t axi_rsp = '0;
  int n_pass = 0, n_total = 0;
  int aw_lat = 0, w_lat = 0, irq_dly = 5, last_lat = 0;
  logic [63:0] err_addr = '1;
  logic [31:0] rd_hdr_val = 0, rd_pld_val = 0, last_hdr = 0, last_pld = 0;
  logic last_err = 0, last_to = 0, txn_active = 0, err_seen = 0;
  ent_t log_q[$];
  scmi_mbox_initiator #(
    .AXI_ADDR_WIDTH (32),
    .MBOX_BASE      (BASE),
    .TIMEOUT_CYCLES (TO),
    .axi_lite_req_t (mbox_axi_req_t),
    .axi_lite_resp_t(mbox_axi_rsp_t)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_hdr_i(req_hdr), .req_payload_i(req_payload), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_hdr_o(rsp_hdr), .rsp_payload_o(rsp_payload),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout), .irq_completion_i(irq),
    .axi_req_o(axi_req), .axi_rsp_i(axi_rsp), .busy_o(busy)
  );
  initial forever #5 clk = ~clk;
  function automatic logic [63:0] addr_of(logic [7:0] o);
    return (BASE + 64'(o)) & 64'hFFFF_FFFF;
  endfunction
  function automatic logic exp_timeout();
    return irq_dly < 0 || irq_dly > TO;
  endfunction
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
  endtask
  // Subordinate + checker: drives readies/responses at negedge, so handshakes land on the next posedge
  initial begin : monitor
    logic aw_have, w_have, aw_hs, w_hs, ar_hs, b_hs, r_hs, req_hs_p, rsp_hs_p, w_pend_p, rv_p, lat_done;
    logic [63:0] wa, ra;
    logic [31:0] wd, ph, pp;
    logic [1:0] pf;
    int aw_wait, w_wait, irq_cd, lat;
    aw_have = 0; w_have = 0; aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
    req_hs_p = 0; rsp_hs_p = 0; w_pend_p = 0; rv_p = 0; lat_done = 1;
    wa = 0; ra = 0; wd = 0; ph = 0; pp = 0; pf = 0; aw_wait = 0; w_wait = 0; irq_cd = -1; lat = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        axi_rsp = '0; irq = 0; irq_cd = -1; txn_active = 0;
        aw_have = 0; w_have = 0; aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
        req_hs_p = 0; rsp_hs_p = 0; w_pend_p = 0; rv_p = 0; aw_wait = 0; w_wait = 0;
        chk("reset_outputs", {req_ready, rsp_valid, rsp_err, rsp_timeout, busy, axi_req.aw_valid,
            axi_req.w_valid, axi_req.b_ready, axi_req.ar_valid, axi_req.r_ready, rsp_hdr, rsp_payload}, 0);
        continue;
      end
      if (req_hs_p) begin txn_active = 1; lat = 0; lat_done = 0; err_seen = 0; end
      if (rsp_hs_p) txn_active = 0;
      if (b_hs) axi_rsp.b_valid = 0;
      if (r_hs) axi_rsp.r_valid = 0;
      if (ar_hs) begin
        log_q.push_back('{1'b0, ra, 32'd0});
        axi_rsp.r_valid = 1;
        axi_rsp.r_data = ra == addr_of(O_HDR) ? rd_hdr_val : ra == addr_of(O_PLD) ? rd_pld_val : 32'hDEAD_BEEF;
        axi_rsp.r_resp = ra == err_addr ? 2'b10 : 2'b00;
        if (ra == err_addr) err_seen = 1;
      end
      if (irq_cd > 0) begin irq_cd--; if (irq_cd == 0) irq = 1; end
      if (aw_have && w_have) begin
        log_q.push_back('{1'b1, wa, wd});
        axi_rsp.b_valid = 1;
        axi_rsp.b_resp = wa == err_addr ? 2'b10 : 2'b00;
        if (wa == err_addr) err_seen = 1;
        if (wa == addr_of(O_DB) && irq_dly > 0) irq_cd = irq_dly;
        if (wa == addr_of(O_CMP)) irq = 0;
        aw_have = 0; w_have = 0;
      end
      chk("busy", busy, txn_active);
      chk("req_ready", req_ready, !txn_active);
      if (!txn_active) chk("idle_no_valids", {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid, rsp_valid}, 0);
      if (aw_have) chk("aw_drop_after_hs", axi_req.aw_valid, 0);
      if (w_have) chk("w_drop_after_hs", axi_req.w_valid, 0);
      if (w_pend_p) chk("w_held", axi_req.w_valid, 1);
      if (axi_req.aw_valid) chk("aw_prot", axi_req.aw_prot, 0);
      if (axi_req.w_valid) chk("w_strb", axi_req.w_strb, 4'hF);
      if (rsp_valid) begin
        chk("rsp_hdr", rsp_hdr, exp_timeout() ? 32'd0 : rd_hdr_val);
        chk("rsp_payload", rsp_payload, exp_timeout() ? 32'd0 : rd_pld_val);
        chk("rsp_err", rsp_err, err_seen);
        chk("rsp_timeout", rsp_timeout, exp_timeout());
        last_hdr = rsp_hdr; last_pld = rsp_payload; last_err = rsp_err; last_to = rsp_timeout;
      end
      if (rv_p && !rsp_hs_p) chk("rsp_stable", {rsp_valid, rsp_hdr, rsp_payload, rsp_err, rsp_timeout}, {1'b1, ph, pp, pf});
      if (txn_active && !lat_done) begin
        lat++;
        if (rsp_valid) begin lat_done = 1; last_lat = lat; end
      end
      axi_rsp.aw_ready = axi_req.aw_valid && !aw_have && aw_wait >= aw_lat;
      axi_rsp.w_ready  = axi_req.w_valid && !w_have && w_wait >= w_lat;
      axi_rsp.ar_ready = axi_req.ar_valid;
      aw_hs = axi_req.aw_valid && axi_rsp.aw_ready;
      w_hs  = axi_req.w_valid && axi_rsp.w_ready;
      ar_hs = axi_req.ar_valid && axi_rsp.ar_ready;
      b_hs  = axi_rsp.b_valid && axi_req.b_ready;
      r_hs  = axi_rsp.r_valid && axi_req.r_ready;
      if (aw_hs) begin aw_have = 1; wa = axi_req.aw_addr; aw_wait = 0; end
      else if (axi_req.aw_valid) aw_wait++;
      if (w_hs) begin w_have = 1; wd = axi_req.w_data; w_wait = 0; end
      else if (axi_req.w_valid) w_wait++;
      if (ar_hs) ra = axi_req.ar_addr;
      req_hs_p = req_valid && req_ready;
      rsp_hs_p = rsp_valid && rsp_ready;
      w_pend_p = axi_req.w_valid && !axi_rsp.w_ready;
      rv_p = rsp_valid; ph = rsp_hdr; pp = rsp_payload; pf = {rsp_err, rsp_timeout};
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic accept(input logic [31:0] h, input logic [31:0] p);
    int n;
    log_q.delete();
    req_hdr = h; req_payload = p; req_valid = 1;
    n = 0;
    do begin tick(); n++; end while (!busy && n < 20);
    req_valid = 0;
    chk("req_accepted", busy, 1);
  endtask
  task automatic run_req(input logic [31:0] h, input logic [31:0] p, input int hold);
    int n;
    rsp_ready = (hold == 0);
    accept(h, p);
    n = 0;
    while (!rsp_valid && n < 400) begin tick(); n++; end
    chk("rsp_arrived", rsp_valid, 1);
    if (hold > 0) begin
      repeat (hold) tick();
      chk("rsp_hold_state", {busy, req_ready, rsp_valid}, 3'b101);
      rsp_ready = 1;
    end
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk("back_to_idle", busy, 0);
  endtask
  task automatic check_log(input logic [31:0] h, input logic [31:0] p, input logic to);
    ent_t e[$];
    e.push_back('{1'b1, addr_of(O_LEN), 32'd8});
    e.push_back('{1'b1, addr_of(O_HDR), h});
    e.push_back('{1'b1, addr_of(O_PLD), p});
    e.push_back('{1'b1, addr_of(O_DB), 32'd1});
    if (!to) begin
      e.push_back('{1'b0, addr_of(O_HDR), 32'd0});
      e.push_back('{1'b0, addr_of(O_PLD), 32'd0});
    end
    e.push_back('{1'b1, addr_of(O_CMP), 32'd0});
    chk("axi_txn_count", log_q.size(), e.size());
    for (int i = 0; i < e.size() && i < log_q.size(); i++)
      chk($sformatf("axi_txn_%0d", i), {log_q[i].wr, log_q[i].addr, log_q[i].data}, {e[i].wr, e[i].addr, e[i].data});
  endtask
  initial begin : stim
    int n;
    repeat (3) tick();
    rst = 0;
    tick();
    // basic transfer, irq 5 cycles after the doorbell
    rd_hdr_val = 32'hC0DE_0010; rd_pld_val = 32'h0000_1234;
    run_req(32'h10, 32'hA5, 0);
    check_log(32'h10, 32'hA5, 0);
    chk("basic_latency", last_lat, 20);
    chk("basic_rsp", {last_hdr, last_pld, last_err, last_to}, {32'hC0DE_0010, 32'h0000_1234, 2'b00});
    // W accepted three cycles after AW
    w_lat = 3; rd_hdr_val = 32'h0201_0010; rd_pld_val = 32'hFFFF_FFFE;
    run_req(32'h0000_4321, 32'h8765_0000, 0);
    check_log(32'h0000_4321, 32'h8765_0000, 0);
    chk("slow_w_latency", last_lat, 35);
    // no irq: timeout after 16 wait cycles, reads skipped
    w_lat = 0; irq_dly = -1;
    run_req(32'h22, 32'h33, 0);
    check_log(32'h22, 32'h33, 1);
    chk("timeout_latency", last_lat, 27);
    chk("timeout_rsp", {last_hdr, last_pld, last_err, last_to}, {64'd0, 2'b01});
    // irq on the expiry cycle resolves as irq
    irq_dly = 16; rd_hdr_val = 32'h5A5A_0001; rd_pld_val = 32'h0;
    run_req(32'h44, 32'h55, 0);
    check_log(32'h44, 32'h55, 0);
    chk("irq_at_expiry_latency", last_lat, 31);
    chk("irq_at_expiry_to", last_to, 0);
    // SLVERR on doorbell B
    irq_dly = 5; err_addr = addr_of(O_DB);
    run_req(32'h66, 32'h77, 0);
    check_log(32'h66, 32'h77, 0);
    chk("slverr_flag", {last_err, last_to}, 2'b10);
    err_addr = '1;
    // reset during WR_PLD
    accept(32'h99, 32'hAA);
    n = 0;
    while (!(axi_req.aw_valid && axi_req.aw_addr == addr_of(O_PLD)) && n < 50) begin tick(); n++; end
    chk("reached_wr_pld", axi_req.aw_valid && axi_req.aw_addr == addr_of(O_PLD), 1);
    rst = 1; #1;
    chk("reset_abort", {busy, req_ready, axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready}, 0);
    repeat (2) tick();
    rst = 0;
    tick();
    run_req(32'hBB, 32'hCC, 0);
    check_log(32'hBB, 32'hCC, 0);
    // consumer stalls the response for 10 cycles
    rd_hdr_val = 32'h1357_9BDF; rd_pld_val = 32'h2468_ACE0;
    run_req(32'hDD, 32'hEE, 10);
    check_log(32'hDD, 32'hEE, 0);
    chk("stall_rsp", {last_hdr, last_pld}, {32'h1357_9BDF, 32'h2468_ACE0});
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/scmi_mbox_initiator.md
SCMI_MBOX_INITIATOR -- requirements
Module: scmi_mbox_initiator

Interface
REQ-001 Parameter AXI_ADDR_WIDTH, default 64: AXI-lite address width; the data width is fixed at 32.
REQ-002 Parameter MBOX_BASE, default 0: base address of the mailbox register window.
REQ-003 Parameter TIMEOUT_CYCLES, default 0: completion wait limit in cycles; 0 disables the timeout.
REQ-004 Parameters axi_lite_req_t / axi_lite_resp_t, default logic: AXI-lite channel structs.
REQ-005 clk_i  in  1  single clock; all logic on its rising edge.
REQ-006 rst_i  in  1  asynchronous, active-high reset.
REQ-007 req_valid_i / req_ready_o  in/out  1  command handshake.
REQ-008 req_hdr_i / req_payload_i  in  32/32  SCMI message header and first payload word.
REQ-009 rsp_valid_o / rsp_ready_i  out/in  1  response handshake.
REQ-010 rsp_hdr_o / rsp_payload_o  out  32/32  header and payload read back after completion.
REQ-011 rsp_err_o  out  1  any non-OKAY AXI response during the transfer.
REQ-012 rsp_timeout_o  out  1  completion wait expired.
REQ-013 irq_completion_i  in  1  level completion interrupt from the mailbox.
REQ-014 axi_req_o / axi_rsp_i  out/in  struct  AXI-lite manager port.
REQ-015 busy_o  out  1  high whenever the FSM is not IDLE.

Function
REQ-016 The FSM SHALL have these states: IDLE, WR_LEN, WR_HDR, WR_PLD, WR_DB, WAIT_IRQ, RD_HDR, RD_PLD, CLR_CMP, RESP.
REQ-017 In IDLE, req_ready_o SHALL be 1; on req_valid_i&&req_ready_o, the block SHALL capture header/payload, clear the error flags, and go to WR_LEN.
REQ-018 Write states: WR_LEN writes 8 to base+SCMI_OFS_LENGTH; WR_HDR writes hdr to base+SCMI_OFS_HDR; WR_PLD writes payload to base+SCMI_OFS_PAYLOAD; WR_DB writes 1 to base+SCMI_OFS_DOORBELL; CLR_CMP writes 0 to base+SCMI_OFS_COMPLETION.
REQ-019 Each write SHALL assert aw_valid and w_valid in the same cycle, with wstrb 4'hF and prot 0.
REQ-020 aw_valid and w_valid SHALL each drop independently after their own handshake.
REQ-021 b_ready SHALL be held high until the B handshake, and the state SHALL advance only in the B handshake cycle.
REQ-022 Each read SHALL assert ar_valid until its handshake, then r_ready until the R handshake; the r data SHALL be latched and the state advanced in the R handshake cycle.
REQ-023 The block SHALL have at most one outstanding transaction; no channel valid is asserted in IDLE, WAIT_IRQ or RESP.
REQ-024 In WAIT_IRQ, the block SHALL go to RD_HDR in the first cycle irq_completion_i is sampled high.
REQ-025 In WAIT_IRQ with TIMEOUT_CYCLES>0, a counter SHALL start at 0 on entry; when it reaches TIMEOUT_CYCLES-1 without an irq, the block SHALL set the timeout flag and go to CLR_CMP, skipping the reads; rsp_hdr_o and rsp_payload_o are then 0.
REQ-026 An irq and expiry in the same cycle SHALL resolve as irq: no timeout flag.
REQ-027 Flow after the reads: RD_HDR -> RD_PLD -> CLR_CMP -> RESP.
REQ-028 A bresp/rresp other than OKAY SHALL set the sticky error flag and the sequence SHALL continue unchanged.
REQ-029 In RESP, rsp_valid_o SHALL be 1 with its outputs stable; on rsp_ready_i the block SHALL return to IDLE.
REQ-030 The minimum request-to-rsp_valid_o latency with single-cycle handshakes is 2 cycles per AXI transaction plus the irq wait.
REQ-031 All addresses SHALL be MBOX_BASE plus the offset, truncated to AXI_ADDR_WIDTH.

Reset
REQ-032 While rst_i is high, the block SHALL be in IDLE and all valid/ready outputs, rsp data, flags, counters and busy_o SHALL be 0.
REQ-033 req_ready_o SHALL be 0 while rst_i is high and 1 from the first cycle after release.
REQ-034 Reset asserted mid-transaction SHALL abort immediately; no recovery of the in-flight AXI beat is attempted.

Structure
REQ-035 Package scmi_mbox_pkg SHALL hold the FSM state enum and the offsets SCMI_OFS_LENGTH=0x14, SCMI_OFS_HDR=0x18, SCMI_OFS_PAYLOAD=0x1C, SCMI_OFS_DOORBELL=0x20, SCMI_OFS_COMPLETION=0x24.
REQ-036 The AXI-lite single-beat manager handshake SHALL be one sub-module, axi_lite_single_mgr, exposing a start/write/addr/wdata input set and a done/rdata/err output set.

Verification
REQ-037 hdr=0x10, pld=0xA5, irq 5 cycles after the doorbell -> writes {0x14:8, 0x18:0x10, 0x1C:0xA5, 0x20:1}, reads 0x18/0x1C, write 0x24:0; rsp_valid_o with the read data, err=0, timeout=0.
REQ-038 AW accepted 3 cycles before W -> aw_valid drops after its handshake, w_valid is held, and there is exactly one write per register.
REQ-039 TIMEOUT_CYCLES=16 with no irq -> timeout=1 after 16 wait cycles, only the 0x24 clear is issued, rsp data 0.
REQ-040 SLVERR on the doorbell B response -> rsp_err_o=1 and the sequence still completes.
REQ-041 rst_i pulsed during WR_PLD -> all outputs 0 at once; a new request afterwards runs cleanly from WR_LEN.
REQ-042 rsp_ready_i held low for 10 cycles -> rsp_valid_o stable, req_ready_o=0, busy_o=1 until accepted.
